// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths and constants for the operand fetch stage
package operand_fetch_pkg;

    localparam int DATA_W = 32;
    localparam int REG_N = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/operand_fetch_reg_file.sv
// rtl/operand_fetch_reg_file.sv - register array with two async read ports and one sync write port
module reg_file
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int REG_N = operand_fetch_pkg::REG_N
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [operand_fetch_pkg::ADDR_W-1:0] rd_a_addr_i,
    output logic [DATA_W-1:0]                    rd_a_data_o,
    input  logic [operand_fetch_pkg::ADDR_W-1:0] rd_b_addr_i,
    output logic [DATA_W-1:0]                    rd_b_data_o,
    input  logic                                 wr_en_i,
    input  logic [operand_fetch_pkg::ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]                    wr_data_i
);

    logic [DATA_W-1:0] regs [REG_N];

    // Write port: reset clears every entry; writes to r0 or beyond REG_N are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != ZERO_REG) && (int'(wr_addr_i) < REG_N)) begin
            regs[wr_addr_i] <= wr_data_i;
        end
    end

    // Read ports: r0 and unimplemented addresses read as zero
    always_comb begin
        rd_a_data_o = '0;
        rd_b_data_o = '0;
        if ((rd_a_addr_i != ZERO_REG) && (int'(rd_a_addr_i) < REG_N)) begin
            rd_a_data_o = regs[rd_a_addr_i];
        end
        if ((rd_b_addr_i != ZERO_REG) && (int'(rd_b_addr_i) < REG_N)) begin
            rd_b_data_o = regs[rd_b_addr_i];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read, writeback bypass and stall-hold stage feeding the ALU
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int REG_N = operand_fetch_pkg::REG_N
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 valid_i,
    input  logic                                 stall_i,
    input  logic [operand_fetch_pkg::ADDR_W-1:0] rs_addr_i,
    input  logic [operand_fetch_pkg::ADDR_W-1:0] rt_addr_i,
    input  logic [DATA_W-1:0]                    imm_i,
    input  logic                                 use_imm_i,
    input  logic                                 wr_en_i,
    input  logic [operand_fetch_pkg::ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]                    wr_data_i,
    output logic [DATA_W-1:0]                    src1_o,
    output logic [DATA_W-1:0]                    src2_o,
    output logic                                 valid_o
);

    logic [DATA_W-1:0] rd_rs_data;
    logic [DATA_W-1:0] rd_rt_data;
    logic [ADDR_W-1:0] rs_lat;
    logic [ADDR_W-1:0] rt_lat;
    logic              use_imm_lat;
    logic              advance;
    logic [DATA_W-1:0] src1_next;
    logic [DATA_W-1:0] src2_next;
    logic              valid_next;
    logic [ADDR_W-1:0] rs_lat_next;
    logic [ADDR_W-1:0] rt_lat_next;
    logic              use_imm_lat_next;

    reg_file #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_reg_file (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_a_addr_i (rs_addr_i),
        .rd_a_data_o (rd_rs_data),
        .rd_b_addr_i (rt_addr_i),
        .rd_b_data_o (rd_rt_data),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i)
    );

    // An empty output stage always accepts, so a stall only holds live data
    assign advance = !stall_i || !valid_o;

    // Next-state: capture with write-first bypass on advance, refresh latched operands while held
    always_comb begin
        src1_next        = src1_o;
        src2_next        = src2_o;
        valid_next       = valid_o;
        rs_lat_next      = rs_lat;
        rt_lat_next      = rt_lat;
        use_imm_lat_next = use_imm_lat;
        if (advance) begin
            valid_next = valid_i;
            if (valid_i) begin
                rs_lat_next      = rs_addr_i;
                rt_lat_next      = rt_addr_i;
                use_imm_lat_next = use_imm_i;
                if (wr_en_i && (wr_addr_i == rs_addr_i) && (rs_addr_i != ZERO_REG)) begin
                    src1_next = wr_data_i;
                end else begin
                    src1_next = rd_rs_data;
                end
                if (use_imm_i) begin
                    src2_next = imm_i;
                end else if (wr_en_i && (wr_addr_i == rt_addr_i) && (rt_addr_i != ZERO_REG)) begin
                    src2_next = wr_data_i;
                end else begin
                    src2_next = rd_rt_data;
                end
            end
        end else begin
            // A writeback landing on a held source must not leave a stale operand behind
            if (wr_en_i && (wr_addr_i == rs_lat) && (rs_lat != ZERO_REG)) begin
                src1_next = wr_data_i;
            end
            if (wr_en_i && !use_imm_lat && (wr_addr_i == rt_lat) && (rt_lat != ZERO_REG)) begin
                src2_next = wr_data_i;
            end
        end
    end

    // Output stage registers; reset drops any request in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src1_o      <= '0;
            src2_o      <= '0;
            valid_o     <= 1'b0;
            rs_lat      <= '0;
            rt_lat      <= '0;
            use_imm_lat <= 1'b0;
        end else begin
            src1_o      <= src1_next;
            src2_o      <= src2_next;
            valid_o     <= valid_next;
            rs_lat      <= rs_lat_next;
            rt_lat      <= rt_lat_next;
            use_imm_lat <= use_imm_lat_next;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        stall_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic [31:0] imm_i;
    logic        use_imm_i;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] src1_o;
    logic [31:0] src2_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .rs_addr_i (rs_addr_i),
        .rt_addr_i (rt_addr_i),
        .imm_i     (imm_i),
        .use_imm_i (use_imm_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .src1_o    (src1_o),
        .src2_o    (src2_o),
        .valid_o   (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i   = 1'b0;
        wr_en_i   = 1'b0;
        wr_addr_i = 5'd0;
        wr_data_i = 32'h0;
    endtask

    task automatic req(input logic [4:0] rs, input logic [4:0] rt, input logic ui, input logic [31:0] imm);
        valid_i   = 1'b1;
        rs_addr_i = rs;
        rt_addr_i = rt;
        use_imm_i = ui;
        imm_i     = imm;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] s1, input logic [31:0] s2);
        check({tag, ".valid"}, {31'h0, valid_o}, {31'h0, v});
        check({tag, ".src1"}, src1_o, s1);
        check({tag, ".src2"}, src2_o, s2);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; rs_addr_i = '0; rt_addr_i = '0;
        imm_i = '0; use_imm_i = 1'b0;
        idle();
        #1;
        tick(); tick();
        expect_out("reset", 1'b0, 32'h0, 32'h0);

        // r0 ignores writes, including one coinciding with the request
        rst_i = 1'b0;
        wr(5'd0, 32'hDEADBEEF);
        tick();
        req(5'd0, 5'd0, 1'b0, 32'h0);
        tick();
        expect_out("zero_reg", 1'b1, 32'h0, 32'h0);

        // Same-cycle writeback bypass into src1, immediate into src2
        idle();
        req(5'd5, 5'd1, 1'b1, 32'hFFFFFFFC);
        wr(5'd5, 32'h12345678);
        tick();
        expect_out("bypass", 1'b1, 32'h12345678, 32'hFFFFFFFC);

        // Stall refresh of src2
        idle(); wr(5'd3, 32'd1); tick();
        idle(); wr(5'd4, 32'd2); tick();
        idle();
        stall_i = 1'b1;
        req(5'd3, 5'd4, 1'b0, 32'h0);
        tick();
        expect_out("stall_cap", 1'b1, 32'd1, 32'd2);
        req(5'd5, 5'd5, 1'b0, 32'h0);
        wr(5'd4, 32'd9);
        tick();
        expect_out("stall_refresh", 1'b1, 32'd1, 32'd9);
        idle(); valid_i = 1'b1;
        tick();
        expect_out("stall_hold", 1'b1, 32'd1, 32'd9);
        stall_i = 1'b0; idle();
        tick();
        expect_out("stall_release", 1'b0, 32'd1, 32'd9);
        req(5'd4, 5'd0, 1'b0, 32'h0);
        tick();
        expect_out("r4_written", 1'b1, 32'd9, 32'd0);

        // Latched immediate is never overwritten by a refresh
        idle();
        req(5'd6, 5'd4, 1'b1, 32'd7);
        tick();
        expect_out("imm_cap", 1'b1, 32'd0, 32'd7);
        idle(); stall_i = 1'b1; wr(5'd4, 32'h55);
        tick();
        expect_out("imm_protect", 1'b1, 32'd0, 32'd7);
        idle(); wr(5'd6, 32'h66);
        tick();
        expect_out("imm_rs_refresh", 1'b1, 32'h66, 32'd7);

        // Bubble: empty stage held under stall, next request captured at once
        idle(); stall_i = 1'b0;
        tick();
        expect_out("bubble0", 1'b0, 32'h66, 32'd7);
        stall_i = 1'b1;
        tick();
        expect_out("bubble1", 1'b0, 32'h66, 32'd7);
        tick();
        expect_out("bubble2", 1'b0, 32'h66, 32'd7);
        req(5'd5, 5'd3, 1'b0, 32'h0);
        tick();
        expect_out("bubble_next", 1'b1, 32'h12345678, 32'd1);

        // rs == rt: both operands bypassed identically
        stall_i = 1'b0;
        req(5'd9, 5'd9, 1'b0, 32'h0);
        wr(5'd9, 32'h99);
        tick();
        expect_out("rs_eq_rt", 1'b1, 32'h99, 32'h99);

        // Mid-operation reset beats a simultaneous write and request
        idle(); wr(5'd7, 32'hA5);
        tick();
        idle(); req(5'd7, 5'd7, 1'b0, 32'h0);
        tick();
        expect_out("pre_reset", 1'b1, 32'hA5, 32'hA5);
        rst_i = 1'b1; stall_i = 1'b1;
        wr(5'd8, 32'h88);
        tick();
        expect_out("mid_reset", 1'b0, 32'h0, 32'h0);
        rst_i = 1'b0; idle();
        req(5'd8, 5'd7, 1'b0, 32'h0);
        tick();
        expect_out("post_reset", 1'b1, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of registers, operands and write data.
REQ-002 Parameter REG_N, default 32, SHALL set the register count; address width SHALL be 5 bits.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_i  input  1  SHALL be a synchronous, active-high reset.
REQ-005 valid_i  input  1  SHALL flag a new operand request from decode.
REQ-006 stall_i  input  1  SHALL be the hold request from the downstream ALU stage.
REQ-007 rs_addr_i  input  5  SHALL select the source-1 register.
REQ-008 rt_addr_i  input  5  SHALL select the source-2 register.
REQ-009 imm_i  input  DATA_W  SHALL carry the sign-extended immediate.
REQ-010 use_imm_i  input  1  SHALL select imm_i instead of rt for src2.
REQ-011 wr_en_i  input  1  SHALL enable a writeback this cycle.
REQ-012 wr_addr_i  input  5  SHALL give the writeback destination.
REQ-013 wr_data_i  input  DATA_W  SHALL carry the writeback data (the ALU result).
REQ-014 src1_o  output  DATA_W  SHALL be the registered ALU operand 1.
REQ-015 src2_o  output  DATA_W  SHALL be the registered ALU operand 2.
REQ-016 valid_o  output  1  SHALL flag that src1_o/src2_o hold a live request.

Function
REQ-017 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded.
REQ-018 When wr_en_i=1 and wr_addr_i!=0, the register SHALL update at the clock edge, regardless of stall_i or valid_i.
REQ-019 An "advance" SHALL occur when stall_i=0 or valid_o=0.
REQ-020 On advance: valid_o<=valid_i; if valid_i=1, the operands, rs/rt addresses and use_imm SHALL be captured.
REQ-021 On advance with valid_i=0, src1_o/src2_o SHALL hold their previous values and valid_o SHALL be 0.
REQ-022 Captured src1 SHALL be wr_data_i when wr_en_i=1, wr_addr_i==rs_addr_i and rs_addr_i!=0 (write-first bypass); otherwise it SHALL be the register-array value.
REQ-023 Captured src2 SHALL be imm_i when use_imm_i=1; otherwise it SHALL be rt read with the same bypass rule as REQ-022.
REQ-024 When stalled (stall_i=1, valid_o=1), outputs SHALL hold, except for the stall refresh below.
REQ-025 Stall refresh: if wr_en_i=1 and wr_addr_i matches a latched nonzero source address, that operand SHALL load wr_data_i; src2 SHALL be refreshed only if the latched use_imm is 0.
REQ-026 If rs==rt, both operands SHALL be bypassed or refreshed identically.
REQ-027 Latency SHALL be one cycle, from valid_i sampled to valid_o asserted.
REQ-028 Arithmetic: none; data paths SHALL be pure muxing at DATA_W bits with no truncation.

Reset
REQ-029 When rst_i=1 at an edge, all registers, src1_o, src2_o, valid_o and the latched addresses/use_imm SHALL become 0.
REQ-030 Reset SHALL take priority over a simultaneous write, valid_i or stall_i; a request in flight SHALL be dropped.
REQ-031 The first cycle after reset release SHALL behave as an advance with an empty output stage.

Structure
REQ-032 A shared package SHALL hold DATA_W, REG_N, the address width (5) and the constant ZERO_REG=0.
REQ-033 The register array SHALL be a sub-module, reg_file: two combinational read ports, one synchronous write port, and synchronous reset.
REQ-034 Bypass, refresh and handshake logic SHALL live in operand_fetch.

Verification
REQ-035 Reset/zero: reset, then write r0=0xDEADBEEF, then request rs=0, rt=0 -> src1_o=0, src2_o=0, valid_o=1.
REQ-036 Bypass: write r5=0x12345678 in the same cycle as a request with rs=5, use_imm=1, imm=0xFFFFFFFC -> src1_o=0x12345678, src2_o=0xFFFFFFFC.
REQ-037 Stall refresh: request rs=3, rt=4 (r3=1, r4=2); hold stall_i=1 and write r4=9 -> src1_o=1, src2_o=9, valid_o=1 held until stall_i=0.
REQ-038 Immediate protection: stalled request with use_imm=1, imm=7 and a write to the latched rt -> src2_o stays 7.
REQ-039 Mid-operation reset: valid_o=1 with src1_o=0xA5; assert rst_i with wr_en_i=1 -> next cycle all outputs 0, the written register reads 0.
REQ-040 Bubble: valid_i=0 for 2 cycles with stall_i=1 -> valid_o=0 and operands unchanged; the next valid_i is captured immediately.
